udp_voice_unpack: RTL
=====================

Name: udp_voice_unpack

Overview:
- Receive-side counterpart of the UDP voice transmit path.
- Consumes the received UDP payload byte stream (rc_valid/rc_data) in the gmii_rx_clk domain.
- Frames it into stereo 16-bit sample pairs, buffers them in an internal FIFO and presents them on a valid/ready interface to the playback path.
- Keeps packet, truncation, overflow and sequence-error statistics for debug.

Parameters:
FIFO_DEPTH, 256, sample-pair entries in internal buffer (power of two, 16..1024)
MAX_PKT_BYTES, 1472, maximum payload bytes accepted per packet; excess is discarded
CNT_WIDTH, 16, width of each statistics counter

Ports:
gmii_rx_clk  input  1  125 MHz receive clock, sole clock of the block
rst_n  input  1  asynchronous active-low reset
rc_valid  input  1  payload byte valid; one packet = one contiguous high run
rc_data  input  8  payload byte
smp_valid  output  1  sample pair available
smp_ready  input  1  consumer accepts pair when smp_valid&&smp_ready
smp_ldata  output  16  left sample
smp_rdata  output  16  right sample
fifo_level  output  log2(FIFO_DEPTH)+1  stored pairs, including output register
pkt_cnt  output  CNT_WIDTH  packets completed
trunc_cnt  output  CNT_WIDTH  packets with partial frame or length overrun
ovf_cnt  output  CNT_WIDTH  frames dropped because FIFO full
seq_err_cnt  output  CNT_WIDTH  sequence discontinuities (0 without SEQ_CHECK_EN)

Behaviour:
- Reset: all outputs 0; FIFO empty; state SYNC; expected sequence 0; first-packet flag set.
- States:
  - SYNC: wait for rc_valid=0, then go IDLE. Prevents capturing a packet already in flight when reset releases.
  - IDLE: rc_valid=1 -> HDR (with SEQ_CHECK_EN) or DATA (without). The first byte is consumed in this same cycle.
  - HDR: collect 2 bytes of sequence number, big-endian, then go DATA. rc_valid falls in HDR -> trunc_cnt++, pkt_cnt++, go IDLE.
  - DATA: bytes are ordered L_hi, L_lo, R_hi, R_lo; a 2-bit byte index wraps every 4 bytes.
    - On the 4th byte, push the pair into the FIFO.
    - rc_valid falls -> pkt_cnt++; if byte index != 0, the partial frame is discarded and trunc_cnt++; go IDLE.
    - Byte count (header included) reaches MAX_PKT_BYTES while rc_valid is still 1 -> trunc_cnt++, go DROP.
  - DROP: ignore bytes; on rc_valid=0 -> pkt_cnt++, go IDLE.
- Packet end is detected on the first cycle rc_valid=0. A new packet may start on the very next cycle.
- FIFO write:
  - The write occurs on the edge after the 4th byte is sampled.
  - If the occupancy (fifo_level) equals FIFO_DEPTH at that edge, the frame is dropped and ovf_cnt++. This holds even if a read happens in the same cycle.
  - Partial frames are never written.
- Output:
  - First-word-fall-through with a registered output stage.
  - smp_valid rises 2 cycles after the edge sampling the 4th byte, when the FIFO was empty.
  - smp_ldata/smp_rdata are stable while smp_valid=1 and smp_ready=0.
  - One transfer per cycle maximum. Back-to-back transfers are sustained while data is stored.
- fifo_level updates on the write/read edge. Simultaneous write and read leave it unchanged.
- Counters wrap modulo 2^CNT_WIDTH.
- Asserting reset mid-packet clears everything immediately and the block returns to SYNC.

Optional Feature:
SEQ_CHECK_EN
- Defined:
  - Each packet begins with a 16-bit big-endian sequence number.
  - For the first packet after reset, the sequence is accepted without check.
  - Afterwards, if received != expected, seq_err_cnt++. Payload is still accepted.
  - Expected = received+1 (mod 2^16), computed after every packet whose header completed.
- Not defined: no header state; every byte is payload; seq_err_cnt tied to 0.

Test Plan:
- Reset, then one 1024-byte packet, bytes i=0..1023 = i[7:0], smp_ready=1 -> (SEQ_CHECK_EN off) 256 pairs. First pair L=0x0001, R=0x0203. pkt_cnt=1, other counters 0.
- Reset released while rc_valid=1 mid-packet, then a clean 8-byte packet -> the first packet is ignored entirely; exactly 2 pairs are output; pkt_cnt=1.
- 10-byte packet -> 2 pairs, trunc_cnt=1, pkt_cnt=1. Then an immediate next packet (1 idle cycle) of 4 bytes 0xAA,0xBB,0xCC,0xDD -> pair L=0xAABB, R=0xCCDD.
- smp_ready=0, FIFO_DEPTH=256, send 1100 bytes -> fifo_level=256, ovf_cnt=19. Raising smp_ready yields the first 256 pairs in order.
- Packet of MAX_PKT_BYTES+8 bytes -> 368 pairs, trunc_cnt=1, pkt_cnt=1; remaining 8 bytes discarded.
- SEQ_CHECK_EN defined: packets with seq 5, 6, 8 -> seq_err_cnt=1. The 2 header bytes are not output as samples.

Source files
------------

// File: rtl/udp_voice_unpack.sv
// Receive UDP voice payload bytes, frame into stereo 16-bit pairs, buffer in a FWFT FIFO.
// Define SEQ_CHECK_EN to expect a 16-bit big-endian sequence header on each packet.
module udp_voice_unpack #(
  parameter int FIFO_DEPTH    = 256,
  parameter int MAX_PKT_BYTES = 1472,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                        gmii_rx_clk,
  input  logic                        rst_n,
  input  logic                        rc_valid,
  input  logic [7:0]                  rc_data,
  output logic                        smp_valid,
  input  logic                        smp_ready,
  output logic [15:0]                 smp_ldata,
  output logic [15:0]                 smp_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]        pkt_cnt,
  output logic [CNT_WIDTH-1:0]        trunc_cnt,
  output logic [CNT_WIDTH-1:0]        ovf_cnt,
  output logic [CNT_WIDTH-1:0]        seq_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [BW-1:0] MAX_BYTES = BW'(MAX_PKT_BYTES);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

  state_t               state_q;
  logic [1:0]           idx_q;
  logic [BW-1:0]        bcnt_q;
  logic [23:0]          part_q;
  logic                 pend_vld_q;
  logic [31:0]          pend_data_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, trunc_cnt_q, ovf_cnt_q;

`ifdef SEQ_CHECK_EN
  logic [7:0]           seq_hi_q;
  logic [15:0]          seq_exp_q;
  logic                 first_q;
  logic [CNT_WIDTH-1:0] seq_err_cnt_q;
  assign seq_err_cnt = seq_err_cnt_q;
`else
  assign seq_err_cnt = '0;
`endif

  // Packet framing; a completed pair is staged in pend_* and written one edge later.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      idx_q       <= '0;
      bcnt_q      <= '0;
      part_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
`ifdef SEQ_CHECK_EN
      seq_hi_q      <= '0;
      seq_exp_q     <= '0;
      first_q       <= 1'b1;
      seq_err_cnt_q <= '0;
`endif
    end else begin
      pend_vld_q <= 1'b0;
      case (state_q)
        S_SYNC: if (!rc_valid) state_q <= S_IDLE;
        S_IDLE: begin
          if (rc_valid) begin
            bcnt_q <= BW'(1);
`ifdef SEQ_CHECK_EN
            seq_hi_q <= rc_data;
            state_q  <= S_HDR;
`else
            part_q[23:16] <= rc_data;
            idx_q         <= 2'd1;
            state_q       <= S_DATA;
`endif
          end
        end
        S_HDR: begin
          if (!rc_valid) begin
            pkt_cnt_q   <= pkt_cnt_q + CNT_ONE;
            trunc_cnt_q <= trunc_cnt_q + CNT_ONE;
            state_q     <= S_IDLE;
          end else begin
`ifdef SEQ_CHECK_EN
            if (!first_q && ({seq_hi_q, rc_data} != seq_exp_q))
              seq_err_cnt_q <= seq_err_cnt_q + CNT_ONE;
            seq_exp_q <= {seq_hi_q, rc_data} + 16'd1;
            first_q   <= 1'b0;
`endif
            bcnt_q  <= bcnt_q + BW'(1);
            idx_q   <= 2'd0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (!rc_valid) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
            if (idx_q != 2'd0) trunc_cnt_q <= trunc_cnt_q + CNT_ONE;
            state_q <= S_IDLE;
          end else if (bcnt_q == MAX_BYTES) begin
            trunc_cnt_q <= trunc_cnt_q + CNT_ONE;
            state_q     <= S_DROP;
          end else begin
            bcnt_q <= bcnt_q + BW'(1);
            idx_q  <= idx_q + 2'd1;
            case (idx_q)
              2'd0:    part_q[23:16] <= rc_data;
              2'd1:    part_q[15:8]  <= rc_data;
              2'd2:    part_q[7:0]   <= rc_data;
              default: begin
                pend_vld_q  <= 1'b1;
                pend_data_q <= {part_q, rc_data};
              end
            endcase
          end
        end
        S_DROP: begin
          if (!rc_valid) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d, mem_cnt;
  logic          out_vld_q;
  logic [31:0]   out_data_q;
  logic          wr_ok, rd_take, load;

  // Occupancy counts the output register too, so a full check uses level_q directly.
  always_comb begin
    wr_ok   = pend_vld_q && (level_q != FULL_LVL);
    rd_take = out_vld_q && smp_ready;
    mem_cnt = level_q - {{AW{1'b0}}, out_vld_q};
    load    = (mem_cnt != '0) && (!out_vld_q || smp_ready);
    level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_take);
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= pend_data_q;
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      level_q <= level_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pend_vld_q && !wr_ok) ovf_cnt_q <= ovf_cnt_q + CNT_ONE;
      if (load) begin
        out_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        out_vld_q  <= 1'b1;
      end else if (rd_take) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign smp_valid  = out_vld_q;
  assign smp_ldata  = out_data_q[31:16];
  assign smp_rdata  = out_data_q[15:0];
  assign fifo_level = level_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign trunc_cnt  = trunc_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;
endmodule
